// File: rtl/motor_bus_master.sv
// Host-side initiator for the motor-board serial bus: sends setpoint / status-request
// frames byte by byte to a UART and receives, checks and unpacks the 30-byte status reply.
module motor_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_type,
  input  logic [7:0]         cmd_id,
  input  logic signed [31:0] cmd_setpoint,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               busy,
  output logic               status_valid,
  output logic [7:0]         status_id,
  output logic [7:0]         status_control_mode,
  output logic signed [31:0] enc0_position,
  output logic signed [31:0] enc1_position,
  output logic signed [31:0] enc0_velocity,
  output logic signed [31:0] enc1_velocity,
  output logic [15:0]        current_phase1,
  output logic [15:0]        current_phase2,
  output logic [15:0]        current_phase3,
  output logic               rx_error,
  output logic               timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RX_MAGIC = 32'h1CEB00DA;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_MAGIC, RECV, CHECK} state_t;

  state_t state, state_nxt;

  logic [87:0]      frame;
  logic [87:0]      frame_new;
  logic [3:0]       byte_idx;
  logic             is_status;
  logic [7:0]       id_q;
  logic             ready_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      magic_sr;
  logic [31:0]      magic_shift;
  logic [4:0]       pl_cnt;
  logic [207:0]     payload;
  logic [15:0]      rx_crc;
  logic [15:0]      crc_st;
  logic [15:0]      crc_sp;
  logic             accept;
  logic             tx_last;
  logic             tx_fire;
  logic             pl_last;
  logic             tmo_hit;
  logic             reply_ok;

  // CRC16, poly 0x8005, MSB of the byte enters first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    crc_st = crc16_byte(16'hFFFF, cmd_id);
    crc_sp = crc16_byte(crc16_byte(crc16_byte(crc16_byte(crc_st,
               cmd_setpoint[31:24]), cmd_setpoint[23:16]), cmd_setpoint[15:8]),
               cmd_setpoint[7:0]);
    if (cmd_type) frame_new = {32'h1CE1CEBB, cmd_id, crc_st, 32'h0};
    else          frame_new = {32'hD0D0D0D0, cmd_id, cmd_setpoint, crc_sp};
  end

  assign accept      = (state == IDLE) && ready_q && cmd_valid;
  assign tx_fire     = (state == SEND) && tx_ready;
  assign tx_last     = byte_idx == (is_status ? 4'd6 : 4'd10);
  assign magic_shift = {magic_sr[23:0], rx_data};
  assign pl_last     = pl_cnt == 5'd25;
  assign tmo_hit     = tmo_cnt == TMO_LAST;
  assign reply_ok    = (rx_crc == payload[15:0]) && (payload[207:200] == id_q);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: begin
        if (tx_fire && tx_last)
          state_nxt = (is_status && id_q != 8'hFF) ? WAIT_MAGIC : IDLE;
      end
      WAIT_MAGIC: begin
        if (tmo_hit)                                 state_nxt = IDLE;
        else if (rx_valid && magic_shift == RX_MAGIC) state_nxt = RECV;
      end
      // A final payload byte beats the terminal count
      RECV: begin
        if (rx_valid && pl_last) state_nxt = CHECK;
        else if (tmo_hit)        state_nxt = IDLE;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && ready_q;
    busy      = state != IDLE;
    tx_valid  = state == SEND;
    tx_data   = (state == SEND) ? frame[87:80] : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      frame     <= frame_new;
      is_status <= cmd_type;
      id_q      <= cmd_id;
    end else if (tx_fire) begin
      frame <= {frame[79:0], 8'h00};
    end
    if (state != WAIT_MAGIC) magic_sr <= 32'h0;
    else if (rx_valid)       magic_sr <= magic_shift;
    if (state != RECV) begin
      rx_crc <= 16'hFFFF;
    end else if (rx_valid) begin
      payload <= {payload[199:0], rx_data};
      if (pl_cnt < 5'd24) rx_crc <= crc16_byte(rx_crc, rx_data);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ready_q             <= 1'b0;
      byte_idx            <= '0;
      tmo_cnt             <= '0;
      pl_cnt              <= '0;
      status_valid        <= 1'b0;
      rx_error            <= 1'b0;
      timeout             <= 1'b0;
      status_id           <= '0;
      status_control_mode <= '0;
      enc0_position       <= '0;
      enc1_position       <= '0;
      enc0_velocity       <= '0;
      enc1_velocity       <= '0;
      current_phase1      <= '0;
      current_phase2      <= '0;
      current_phase3      <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept)       byte_idx <= '0;
      else if (tx_fire) byte_idx <= byte_idx + 4'd1;
      if (state == WAIT_MAGIC || state == RECV) tmo_cnt <= tmo_cnt + 1'b1;
      else                                      tmo_cnt <= '0;
      if (state != RECV)  pl_cnt <= '0;
      else if (rx_valid)  pl_cnt <= pl_cnt + 5'd1;
      timeout      <= (state == WAIT_MAGIC || state == RECV) && tmo_hit && state_nxt == IDLE;
      status_valid <= (state == CHECK) && reply_ok;
      rx_error     <= (state == CHECK) && !reply_ok;
      if (state == CHECK && reply_ok) begin
        status_id           <= payload[207:200];
        status_control_mode <= payload[199:192];
        enc0_position       <= $signed(payload[191:160]);
        enc1_position       <= $signed(payload[159:128]);
        enc0_velocity       <= $signed(payload[127:96]);
        enc1_velocity       <= $signed(payload[95:64]);
        current_phase1      <= payload[63:48];
        current_phase2      <= payload[47:32];
        current_phase3      <= payload[31:16];
      end
    end
  end

endmodule

// File: tb/tb_motor_bus_master.sv
// Scoreboard bench for motor_bus_master: expected tx bytes and completion events are
// queued by the stimulus, a negedge monitor pops and compares them as the DUT produces them.
module tb_motor_bus_master;

  localparam int TMO = 50;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  mode;
    logic [31:0] e0p;
    logic [31:0] e1p;
    logic [31:0] e0v;
    logic [31:0] e1v;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] p3;
  } stat_t;

  logic               CLK = 1'b0;
  logic               reset_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_type = 1'b0;
  logic [7:0]         cmd_id = 8'h00;
  logic signed [31:0] cmd_setpoint = 32'sd0;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b1;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic               busy;
  logic               status_valid;
  logic [7:0]         status_id;
  logic [7:0]         status_control_mode;
  logic signed [31:0] enc0_position;
  logic signed [31:0] enc1_position;
  logic signed [31:0] enc0_velocity;
  logic signed [31:0] enc1_velocity;
  logic [15:0]        current_phase1;
  logic [15:0]        current_phase2;
  logic [15:0]        current_phase3;
  logic               rx_error;
  logic               timeout;

  motor_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_id(cmd_id), .cmd_setpoint(cmd_setpoint),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .status_valid(status_valid), .status_id(status_id),
    .status_control_mode(status_control_mode),
    .enc0_position(enc0_position), .enc1_position(enc1_position),
    .enc0_velocity(enc0_velocity), .enc1_velocity(enc1_velocity),
    .current_phase1(current_phase1), .current_phase2(current_phase2),
    .current_phase3(current_phase3), .rx_error(rx_error), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_tx_cyc = 0;
  int         last_rx_cyc = 0;
  logic [7:0] tx_exp[$];
  int         evt_exp[$];
  stat_t      stat_exp[$];
  stat_t      last_good;
  logic       bp_mode = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  // Backpressure mode lets one byte in three through
  always @(posedge CLK) begin
    #1;
    tx_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_add(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    repeat (8) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
    return r;
  endfunction

  function automatic logic [191:0] status_vec();
    return {status_id, status_control_mode, enc0_position, enc1_position, enc0_velocity,
            enc1_velocity, current_phase1, current_phase2, current_phase3};
  endfunction

  task automatic handle_evt(input int code);
    int    e;
    stat_t s;
    n_checks++;
    if (evt_exp.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got code %0d, expected none", code);
    end else begin
      e = evt_exp.pop_front();
      n_checks--;
      check("event_kind", code, e);
      if (code == 1 && e == 1 && stat_exp.size() != 0) begin
        s = stat_exp.pop_front();
        check("status_fields", status_vec(), s);
      end
      if (code == 3) check("timeout_latency", cyc - last_tx_cyc, TMO);
      else           check("reply_latency", cyc - last_rx_cyc, 1);
    end
  endtask

  always @(negedge CLK) begin
    logic [7:0] eb;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (tx_valid) begin
        if (stall_prev) check("tx_hold", tx_data, stall_data);
        if (tx_ready) begin
          n_checks++;
          if (tx_exp.size() == 0) begin
            n_fail++;
            $display("FAIL tx_extra_byte: got %0h, expected no byte", tx_data);
          end else begin
            n_checks--;
            eb = tx_exp.pop_front();
            check("tx_byte", tx_data, eb);
          end
          last_tx_cyc = cyc + 1;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          stall_data = tx_data;
        end
      end else begin
        stall_prev = 1'b0;
      end
      if (rx_valid)     last_rx_cyc = cyc + 1;
      if (status_valid) handle_evt(1);
      if (rx_error)     handle_evt(2);
      if (timeout)      handle_evt(3);
    end
  end

  task automatic push_setpoint(input logic [7:0] id, input logic [31:0] sp);
    logic [15:0] c;
    c = crc_add(16'hFFFF, id);
    repeat (4) tx_exp.push_back(8'hD0);
    tx_exp.push_back(id);
    for (int k = 3; k >= 0; k--) begin
      tx_exp.push_back(sp[8*k +: 8]);
      c = crc_add(c, sp[8*k +: 8]);
    end
    tx_exp.push_back(c[15:8]);
    tx_exp.push_back(c[7:0]);
  endtask

  task automatic push_status(input logic [7:0] id);
    logic [15:0] c;
    c = crc_add(16'hFFFF, id);
    tx_exp.push_back(8'h1C); tx_exp.push_back(8'hE1);
    tx_exp.push_back(8'hCE); tx_exp.push_back(8'hBB);
    tx_exp.push_back(id);
    tx_exp.push_back(c[15:8]);
    tx_exp.push_back(c[7:0]);
  endtask

  task automatic issue(input logic t, input logic [7:0] id, input logic [31:0] sp);
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd_type = t; cmd_id = id; cmd_setpoint = sp;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    check("first_byte_latency", tx_valid, 1'b1);
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while ((tx_exp.size() != 0 || tx_valid) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    check("tx_done_in_time", n < 300, 1'b1);
  endtask

  task automatic wait_evt();
    int n = 0;
    while (evt_exp.size() != 0 && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    check("events_seen", evt_exp.size(), 0);
  endtask

  // Three garbage bytes (a partial magic) followed by a full reply frame
  task automatic send_reply(input stat_t s, input logic [7:0] crc_flip);
    logic [7:0]  fr[33];
    logic [15:0] c;
    c = 16'hFFFF;
    fr[0] = 8'h1C; fr[1] = 8'hEB; fr[2] = 8'h00;
    fr[3] = 8'h1C; fr[4] = 8'hEB; fr[5] = 8'h00; fr[6] = 8'hDA;
    for (int k = 0; k < 24; k++) begin
      fr[7+k] = s[191-8*k -: 8];
      c = crc_add(c, fr[7+k]);
    end
    fr[31] = c[15:8];
    fr[32] = c[7:0] ^ crc_flip;
    for (int k = 0; k < 33; k++) begin
      @(posedge CLK); #1;
      rx_data = fr[k];
      rx_valid = 1'b1;
    end
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    stat_t s1, s2, s3, s4;
    s1 = '{id: 8'h05, mode: 8'h02, e0p: 32'hFFFFFF00, e1p: 32'h7FFFFFFF,
           e0v: 32'h80000000, e1v: 32'h00001234, p1: 16'h0001, p2: 16'hFFFF, p3: 16'h0ABC};
    s2 = '{id: 8'h05, mode: 8'h07, e0p: 32'h00000010, e1p: 32'h00000020,
           e0v: 32'h00000030, e1v: 32'h00000040, p1: 16'h1111, p2: 16'h2222, p3: 16'h3333};
    s3 = s2;
    s3.id = 8'h06;
    s4 = s2;
    s4.id = 8'hFF;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_tx_valid", tx_valid, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_pulses", {status_valid, rx_error, timeout}, 3'b000);
    check("reset_status", status_vec(), 192'h0);
    @(negedge CLK) reset_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("ready_after_reset", cmd_ready, 1'b1);

    push_setpoint(8'h03, 32'h12345678);
    issue(1'b0, 8'h03, 32'h12345678);
    wait_tx_done();
    check("setpoint_busy_low", busy, 1'b0);

    bp_mode = 1'b1;
    push_setpoint(8'h03, 32'h12345678);
    issue(1'b0, 8'h03, 32'h12345678);
    wait_tx_done();
    bp_mode = 1'b0;
    check("backpressure_busy_low", busy, 1'b0);

    push_status(8'h05);
    evt_exp.push_back(1);
    stat_exp.push_back(s1);
    issue(1'b1, 8'h05, 32'h0);
    wait_tx_done();
    check("poll_busy_waiting", busy, 1'b1);
    send_reply(s1, 8'h00);
    wait_evt();
    check("enc0_position_neg", enc0_position, -256);
    check("current_phase3", current_phase3, 16'h0ABC);
    last_good = s1;

    push_status(8'h05);
    evt_exp.push_back(2);
    issue(1'b1, 8'h05, 32'h0);
    wait_tx_done();
    send_reply(s2, 8'h01);
    wait_evt();
    check("bad_crc_hold", status_vec(), last_good);

    push_status(8'h05);
    evt_exp.push_back(2);
    issue(1'b1, 8'h05, 32'h0);
    wait_tx_done();
    send_reply(s3, 8'h00);
    wait_evt();
    check("wrong_id_hold", status_vec(), last_good);

    push_status(8'h05);
    evt_exp.push_back(3);
    issue(1'b1, 8'h05, 32'h0);
    wait_tx_done();
    wait_evt();
    #1;
    check("timeout_idle", cmd_ready, 1'b1);

    push_status(8'hFF);
    issue(1'b1, 8'hFF, 32'h0);
    wait_tx_done();
    check("broadcast_idle", busy, 1'b0);
    send_reply(s4, 8'h00);
    repeat (20) @(posedge CLK);
    #1;
    check("broadcast_still_idle", busy, 1'b0);
    check("broadcast_hold", status_vec(), last_good);

    push_setpoint(8'h07, 32'hCAFEF00D);
    issue(1'b0, 8'h07, 32'hCAFEF00D);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_drops_tx_valid", tx_valid, 1'b0);
    check("reset_drops_busy", busy, 1'b0);
    tx_exp.delete();
    @(negedge CLK) reset_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("ready_after_mid_reset", cmd_ready, 1'b1);
    check("status_cleared_by_reset", status_vec(), 192'h0);

    repeat (5) @(posedge CLK);
    check("tx_queue_drained", tx_exp.size(), 0);
    check("event_queue_drained", evt_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
